// File: rtl/tcdm_bank_adapter.sv
// TCDM bank terminal stage: request unpack, SRAM drive, byte-masked RMW.
// Optional stall counter enabled by TCDM_BANK_STALL_CNT_EN.
module tcdm_bank_adapter #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrWidth    = 10,
  parameter int unsigned ReqDataWidth =
    1 + BeWidth + AddrWidth + DataWidth
`ifdef TCDM_BANK_STALL_CNT_EN
  ,
  parameter int unsigned CntWidth     = 16
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ReqDataWidth-1:0] data_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AddrWidth-1:0]    sram_addr_o,
  output logic [DataWidth-1:0]    sram_wdata_o,
  input  logic [DataWidth-1:0]    sram_rdata_i
`ifdef TCDM_BANK_STALL_CNT_EN
  ,
  output logic [CntWidth-1:0]     stall_cnt_o
`endif
);

  typedef enum logic {
    IDLE,
    RMW
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [BeWidth-1:0]   be_q, be_d;

  logic                 req_wen;
  logic [BeWidth-1:0]   req_be;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 be_full;
  logic                 be_none;
  logic                 sram_req;
  logic [DataWidth-1:0] merged;

  assign req_wen   = data_i[ReqDataWidth-1];
  assign req_be    = data_i[ReqDataWidth-2 -: BeWidth];
  assign req_addr  = data_i[DataWidth+AddrWidth-1 -: AddrWidth];
  assign req_wdata = data_i[DataWidth-1:0];
  assign be_full   = &req_be;
  assign be_none   = ~|req_be;

  assign rdata_o   = sram_rdata_i;

  always_comb begin
    merged = sram_rdata_i;
    for (int i = 0; i < int'(BeWidth); i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    gnt_o        = 1'b0;
    sram_req     = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_addr;
    sram_wdata_o = req_wdata;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        unique case (1'b1)
          req_i & ~req_wen: begin
            sram_req = 1'b1;
          end
          req_i & req_wen & be_full: begin
            sram_req  = 1'b1;
            sram_we_o = 1'b1;
          end
          req_i & req_wen & ~be_full & ~be_none: begin
            sram_req = 1'b1;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            be_d     = req_be;
            state_d  = RMW;
          end
          default: ;
        endcase
      end
      RMW: begin
        sram_req     = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_q;
        sram_wdata_o = merged;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // SRAM is idle whenever reset is held, even with a live request
    if (!rst_ni) sram_we_o = 1'b0;
  end

  assign sram_req_o = sram_req & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

`ifdef TCDM_BANK_STALL_CNT_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req_i && !gnt_o && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Directed self-checking bench for tcdm_bank_adapter with an SRAM model.
// Stall counter vectors run when TCDM_BANK_STALL_CNT_EN is defined.
module tb_tcdm_bank_adapter;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int AW = 10;
  localparam int RW = 1 + BW + AW + DW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i;
  logic          gnt_o;
  logic [RW-1:0] data_i;
  logic [DW-1:0] rdata_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i;
`ifdef TCDM_BANK_STALL_CNT_EN
  logic [1:0]    stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  tcdm_bank_adapter #(
    .DataWidth (DW),
    .AddrWidth (AW)
`ifdef TCDM_BANK_STALL_CNT_EN
    ,
    .CntWidth  (2)
`endif
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .data_i       (data_i),
    .rdata_o      (rdata_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
`ifdef TCDM_BANK_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i <= mem[sram_addr_o];
    end
  end

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [BW-1:0] be,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_i  = r;
    data_i = {w, be, a, d};
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    #2;
    check("rst_req", {31'd0, sram_req_o}, 32'd0);
    check("rst_we", {31'd0, sram_we_o}, 32'd0);
    check("rst_gnt0", {31'd0, gnt_o}, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
    #1;
    check("rst_gnt1", {31'd0, gnt_o}, 32'd1);
    check("rst_req1", {31'd0, sram_req_o}, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // full write then read
    step();
    drive(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    @(negedge clk_i);
    check("fw_gnt", {31'd0, gnt_o}, 32'd1);
    check("fw_req", {31'd0, sram_req_o}, 32'd1);
    check("fw_we", {31'd0, sram_we_o}, 32'd1);
    check("fw_addr", {22'd0, sram_addr_o}, 32'd5);
    check("fw_wdata", sram_wdata_o, 32'hDEADBEEF);
    step();
    drive(1'b1, 1'b1, 4'hF, 10'd9, 32'h0BADF00D);
    step();
    drive(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
    @(negedge clk_i);
    check("rd_gnt", {31'd0, gnt_o}, 32'd1);
    check("rd_req", {31'd0, sram_req_o}, 32'd1);
    check("rd_we", {31'd0, sram_we_o}, 32'd0);
    check("rd_addr", {22'd0, sram_addr_o}, 32'd5);
    step();
    drive(1'b1, 1'b0, 4'h0, 10'd9, 32'h0);
    @(negedge clk_i);
    check("rd5_data", rdata_o, 32'hDEADBEEF);
    check("rd9_gnt", {31'd0, gnt_o}, 32'd1);
    step();
    drive(1'b1, 1'b1, 4'hF, 10'd7, 32'h11223344);
    @(negedge clk_i);
    check("rd9_data", rdata_o, 32'h0BADF00D);

    // partial write with a read to the same word held behind it
    step();
    drive(1'b1, 1'b1, 4'h5, 10'd7, 32'hAABBCCDD);
    @(negedge clk_i);
    check("pw0_gnt", {31'd0, gnt_o}, 32'd1);
    check("pw0_req", {31'd0, sram_req_o}, 32'd1);
    check("pw0_we", {31'd0, sram_we_o}, 32'd0);
    check("pw0_addr", {22'd0, sram_addr_o}, 32'd7);
    step();
    drive(1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
    @(negedge clk_i);
    check("pw1_gnt", {31'd0, gnt_o}, 32'd0);
    check("pw1_req", {31'd0, sram_req_o}, 32'd1);
    check("pw1_we", {31'd0, sram_we_o}, 32'd1);
    check("pw1_addr", {22'd0, sram_addr_o}, 32'd7);
    check("pw1_wdata", sram_wdata_o, 32'h11BB33DD);
    step();
    @(negedge clk_i);
    check("pw2_gnt", {31'd0, gnt_o}, 32'd1);
    check("pw2_we", {31'd0, sram_we_o}, 32'd0);
    check("pw2_addr", {22'd0, sram_addr_o}, 32'd7);
    step();
    drive(1'b1, 1'b1, 4'h0, 10'd7, 32'hFFFFFFFF);
    @(negedge clk_i);
    check("pw3_data", rdata_o, 32'h11BB33DD);
    check("nw_gnt", {31'd0, gnt_o}, 32'd1);
    check("nw_req", {31'd0, sram_req_o}, 32'd0);
    step();
    drive(1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
    step();
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk_i);
    check("nw_data", rdata_o, 32'h11BB33DD);

    // reset during the RMW cycle drops the merge
    step();
    drive(1'b1, 1'b1, 4'h1, 10'd7, 32'h000000EE);
    step();
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    #1;
    check("rr_req", {31'd0, sram_req_o}, 32'd1);
    check("rr_we", {31'd0, sram_we_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rr_req0", {31'd0, sram_req_o}, 32'd0);
    check("rr_we0", {31'd0, sram_we_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    drive(1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
    @(negedge clk_i);
    check("rr_gnt", {31'd0, gnt_o}, 32'd1);
    check("rr_rdwe", {31'd0, sram_we_o}, 32'd0);
    step();
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk_i);
    check("rr_data", rdata_o, 32'h11BB33DD);

`ifdef TCDM_BANK_STALL_CNT_EN
    // six back-to-back partial writes, saturating 2-bit counter
    for (int k = 0; k < 12; k++) begin
      step();
      drive(1'b1, 1'b1, 4'h1, 10'd3, 32'h0);
      @(negedge clk_i);
      if (k % 2 == 0) begin
        check($sformatf("stall_%0d", k), {30'd0, stall_cnt_o},
              (k / 2 > 3) ? 32'd3 : 32'(k / 2));
      end
    end
    step();
    drive(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    @(negedge clk_i);
    check("stall_end", {30'd0, stall_cnt_o}, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_adapter.md
Name: tcdm_bank_adapter

Overview:
- Per-bank terminal stage, one instance on each slave port (req_o/gnt_i/data_o/rdata_i) of the radix-2 butterfly TCDM network.
- Unpacks the request payload and drives a single-port SRAM macro with 1-cycle read latency and no byte enables.
- Resolves byte-masked writes with an internal read-modify-write (RMW) sequence.
- Returns read data exactly one cycle after grant, matching the network's fixed response timing.

Parameters:
- DataWidth, 32, SRAM word width in bits; multiple of 8.
- BeWidth, DataWidth/8, byte-enable width; derived, do not override.
- AddrWidth, 10, bank-local word address width.
- ReqDataWidth, 1+BeWidth+AddrWidth+DataWidth, packed request payload width; derived.
- CntWidth, 16, stall counter width (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request from network output port
- gnt_o  out  1  grant to network
- data_i  in  ReqDataWidth  packed payload {wen, be, addr, wdata}, MSB first; wen=1 means write
- rdata_o  out  DataWidth  response data, valid the cycle after a read grant
- sram_req_o  out  1  SRAM chip enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM word address
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read access
- stall_cnt_o  out  CntWidth  stall counter (present only with TCDM_BANK_STALL_CNT_EN)

Behaviour:
- Clock clk_i; reset rst_ni asynchronous active-low. Reset state: FSM=IDLE, hold registers 0.
- Reset output values: gnt_o=req_i (combinational), sram_req_o=0, sram_we_o=0.
- FSM states: IDLE, RMW.
- IDLE:
  - gnt_o=req_i; no request is ever refused.
  - Read (req_i & !wen): sram_req_o=1, we=0, addr=addr.
  - Full write (wen & be all-ones): sram_req_o=1, we=1, addr=addr, wdata=wdata. Stay IDLE.
  - Partial write (wen & be neither 0 nor all-ones): SRAM read at addr; latch addr, wdata, be into hold registers; next state RMW.
  - Null write (wen & be==0): grant, sram_req_o=0. Stay IDLE.
- RMW (exactly one cycle):
  - gnt_o=0 regardless of req_i.
  - sram_req_o=1, we=1, addr=held addr.
  - Per byte i: wdata byte i = held be[i] ? held wdata byte i : sram_rdata_i byte i.
  - Next state IDLE unconditionally.
- rdata_o=sram_rdata_i at all times, purely combinational, no extra register.
  - Meaningful only in the cycle after a read grant; write-response data is don't-care.
- Latency: read data one cycle after grant. Throughput: 1 op/cycle, except a partial write costs 2 cycles.
- Ordering: a request pending during RMW is granted in the following IDLE cycle. A read to the same address then returns the merged data, because the write completed in RMW.
- Reset asserted during RMW: FSM goes to IDLE, pending merge is discarded (write lost), SRAM outputs drop to 0 asynchronously.
- Hold registers load only on a partial-write grant.

Optional Feature:
- Macro TCDM_BANK_STALL_CNT_EN.
- Defined:
  - stall_cnt_o is present.
  - Counter increments each cycle with req_i & !gnt_o; saturates at all-ones and does not wrap.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Write 0xDEADBEEF be=0xF addr=5, then read addr=5 -> both granted immediately, one SRAM write, rdata_o=0xDEADBEEF the cycle after the read grant.
- Mem[7]=0x11223344; write 0xAABBCCDD be=0x5 addr=7 -> cycle 0 SRAM read, cycle 1 SRAM write 0x11BB33DD with gnt_o=0.
- Partial write to addr 7 with a read to addr 7 held on req_i -> read granted in cycle 2, rdata_o=0x11BB33DD in cycle 3.
- Write be=0x0 -> gnt_o=1, sram_req_o=0, memory unchanged.
- Assert rst_ni low during RMW cycle -> sram_req_o=0 immediately, FSM IDLE after release, target word unchanged.
- With TCDM_BANK_STALL_CNT_EN, CntWidth=2, six back-to-back partial writes -> stall_cnt_o counts 1,2,3,3,3 and holds 3.
